// File: rtl/cpu_boot_controller_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cpu_boot_controller_if
// Brief    : Program stream (valid/ready) plus instruction-memory external
//            port between the boot controller and its environment.
// Revision : 1.0 - initial release
// ============================================================================
interface cpu_boot_controller_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 32
);
   logic              s_valid;
   logic [DATA_W-1:0] s_data;
   logic              s_ready;
   logic [ADDR_W-1:0] addr_ext;
   logic              wen_ext;
   logic              ren_ext;
   logic [DATA_W-1:0] wdata_ext;
   logic [DATA_W-1:0] rdata_ext;

   // Controller side: consumes the stream, drives the memory port.
   modport master (
      input  s_valid, s_data, rdata_ext,
      output s_ready, addr_ext, wen_ext, ren_ext, wdata_ext
   );

   modport slave (
      output s_valid, s_data, rdata_ext,
      input  s_ready, addr_ext, wen_ext, ren_ext, wdata_ext
   );
endinterface
`default_nettype wire

// File: rtl/cpu_boot_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cpu_boot_controller
// Brief    : Streams a program into core instruction memory, then runs the
//            core for a bounded or unbounded time. Read-back checksum verify
//            is built when CPU_BOOT_VERIFY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_boot_controller #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 32,
   parameter int WCNT_W = 10,
   parameter int CYC_W  = 32
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic                  start,
   input  logic [WCNT_W-1:0]     num_words,
   input  logic [CYC_W-1:0]      run_cycles,
   input  logic                  stop,
   cpu_boot_controller_if.master bus,
   output logic                  core_rst_n,
   output logic                  cpu_enable,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [CYC_W-1:0]      cycle_count
);
   localparam logic [2:0] c_st_idle = 3'd0;
   localparam logic [2:0] c_st_load = 3'd1;
   localparam logic [2:0] c_st_run  = 3'd3;
   localparam logic [2:0] c_st_done = 3'd4;
`ifdef CPU_BOOT_VERIFY_EN
   localparam logic [2:0] c_st_verify     = 3'd2;
   localparam logic [2:0] c_st_after_load = c_st_verify;
`else
   localparam logic [2:0] c_st_after_load = c_st_run;
`endif
   localparam logic [WCNT_W-1:0] c_max_words = {1'b1, {(WCNT_W-1){1'b0}}};

   logic [2:0]        r_state;
   logic [2:0]        w_state_next;
   logic [WCNT_W-1:0] r_num_words;
   logic [WCNT_W-1:0] r_idx;
   logic [WCNT_W-1:0] w_num_sat;
   logic [CYC_W-1:0]  r_run_cycles;
   logic [CYC_W-1:0]  r_cycle_count;
   logic [CYC_W-1:0]  w_count_inc;
   logic              r_wen;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              w_s_ready;
   logic              w_ren;
   logic              w_accept;
   logic              w_load_last;
   logic              w_run_exit;
`ifdef CPU_BOOT_VERIFY_EN
   logic              r_rd_valid;
   logic              r_error;
   logic [DATA_W-1:0] r_csum_wr;
   logic [DATA_W-1:0] r_csum_rd;
   logic              w_verify_last;
   logic              w_csum_ok;
`endif

   assign w_num_sat   = (num_words > c_max_words) ? c_max_words : num_words;
   assign w_count_inc = r_cycle_count + 1'b1;
   assign w_accept    = bus.s_valid && w_s_ready;
   // The last write pulse is on the port once the index has reached the count.
   assign w_load_last = r_wen && (r_idx == r_num_words);
   assign w_run_exit  = stop || ((r_run_cycles != '0) && (w_count_inc == r_run_cycles));
`ifdef CPU_BOOT_VERIFY_EN
   assign w_verify_last = r_rd_valid && (r_idx == r_num_words);
   assign w_csum_ok     = ((r_csum_rd ^ bus.rdata_ext) == r_csum_wr);
`else
   logic w_unused_rdata;
   assign w_unused_rdata = ^bus.rdata_ext;
`endif

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_st_idle, c_st_done: begin
            if (start) begin
               w_state_next = (w_num_sat == '0) ? c_st_run : c_st_load;
            end
         end
         c_st_load: begin
            if (w_load_last) begin
               w_state_next = c_st_after_load;
            end
         end
`ifdef CPU_BOOT_VERIFY_EN
         c_st_verify: begin
            if (w_verify_last) begin
               w_state_next = w_csum_ok ? c_st_run : c_st_done;
            end
         end
`endif
         c_st_run: begin
            if (w_run_exit) begin
               w_state_next = c_st_done;
            end
         end
         default: w_state_next = c_st_idle;
      endcase
   end

   always_comb begin
      w_s_ready  = (r_state == c_st_load) && (r_idx < r_num_words);
      w_ren      = 1'b0;
`ifdef CPU_BOOT_VERIFY_EN
      w_ren      = (r_state == c_st_verify) && (r_idx < r_num_words);
`endif
      w_addr     = w_ren ? ADDR_W'({r_idx, 2'b00}) : r_addr;
      core_rst_n = (r_state == c_st_run) || (r_state == c_st_done);
      cpu_enable = (r_state == c_st_run);
      busy       = (r_state != c_st_idle) && (r_state != c_st_done);
      done       = (r_state == c_st_done);
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_num_words   <= '0;
         r_run_cycles  <= '0;
         r_cycle_count <= '0;
         r_idx         <= '0;
         r_wen         <= 1'b0;
         r_addr        <= '0;
         r_wdata       <= '0;
`ifdef CPU_BOOT_VERIFY_EN
         r_rd_valid    <= 1'b0;
         r_error       <= 1'b0;
         r_csum_wr     <= '0;
         r_csum_rd     <= '0;
`endif
      end else begin
         r_wen <= 1'b0;
`ifdef CPU_BOOT_VERIFY_EN
         r_rd_valid <= w_ren;
`endif
         case (r_state)
            c_st_idle, c_st_done: begin
               if (start) begin
                  r_num_words   <= w_num_sat;
                  r_run_cycles  <= run_cycles;
                  r_cycle_count <= '0;
                  r_idx         <= '0;
`ifdef CPU_BOOT_VERIFY_EN
                  r_error       <= 1'b0;
                  r_csum_wr     <= '0;
                  r_csum_rd     <= '0;
`endif
               end
            end
            c_st_load: begin
               if (w_accept) begin
                  r_wen   <= 1'b1;
                  r_addr  <= ADDR_W'({r_idx, 2'b00});
                  r_wdata <= bus.s_data;
                  r_idx   <= r_idx + 1'b1;
`ifdef CPU_BOOT_VERIFY_EN
                  r_csum_wr <= r_csum_wr ^ bus.s_data;
`endif
               end
`ifdef CPU_BOOT_VERIFY_EN
               // Index is reused as the read pointer for the verify pass.
               if (w_load_last) begin
                  r_idx <= '0;
               end
`endif
            end
`ifdef CPU_BOOT_VERIFY_EN
            c_st_verify: begin
               if (w_ren) begin
                  r_idx <= r_idx + 1'b1;
               end
               if (r_rd_valid) begin
                  r_csum_rd <= r_csum_rd ^ bus.rdata_ext;
               end
               if (w_verify_last && !w_csum_ok) begin
                  r_error <= 1'b1;
               end
            end
`endif
            c_st_run: begin
               r_cycle_count <= w_count_inc;
            end
            default: ;
         endcase
      end
   end

   assign bus.s_ready   = w_s_ready;
   assign bus.wen_ext   = r_wen;
   assign bus.ren_ext   = w_ren;
   assign bus.addr_ext  = w_addr;
   assign bus.wdata_ext = r_wdata;
   assign cycle_count   = r_cycle_count;
`ifdef CPU_BOOT_VERIFY_EN
   assign error = r_error;
`else
   assign error = 1'b0;
`endif
endmodule
`default_nettype wire

// File: doc/cpu_boot_controller.md
Name: cpu_boot_controller

Overview:
- Sequencer that sits above the single-cycle RISC-V `cpu` top and drives its instruction-memory external port (`addr_ext`/`wen_ext`/`ren_ext`/`wdata_ext`/`rdata_ext`) and its `enable` input.
- On `start`, it streams a program from a valid/ready source into instruction memory, then releases the core for a bounded or unbounded run and reports completion.
- It keeps the core held in reset and disabled while memory is being written.

Parameters:
- ADDR_W, 64, width of `addr_ext`.
- DATA_W, 32, instruction word width.
- WCNT_W, 10, width of the word counter; max program = 2^(WCNT_W-1) = 512 words.
- CYC_W, 32, width of the run-cycle counter.

Ports:
- clk  input  1  main clock
- arst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to load and run; honoured only in IDLE or DONE
- num_words  input  WCNT_W  words to load; sampled on accepted `start`; 0 means skip load; values >512 saturate to 512
- run_cycles  input  CYC_W  run length in cycles; sampled on accepted `start`; 0 means run until `stop`
- stop  input  1  forces RUN to DONE
- s_valid  input  1  program stream word valid
- s_data  input  DATA_W  program stream word
- s_ready  output  1  controller accepts `s_data`
- addr_ext  output  ADDR_W  instruction memory external address (byte address)
- wen_ext  output  1  instruction memory external write enable
- ren_ext  output  1  instruction memory external read enable
- wdata_ext  output  DATA_W  instruction memory external write data
- rdata_ext  input  DATA_W  instruction memory external read data; valid one cycle after `ren_ext`
- core_rst_n  output  1  reset to the core (`arst_n` of `cpu`)
- cpu_enable  output  1  drives the core `enable`
- busy  output  1  state is not IDLE and not DONE
- done  output  1  state is DONE
- error  output  1  verify mismatch (optional feature)
- cycle_count  output  CYC_W  cycles spent in RUN in the current or last run

Behaviour:
- Reset values (async, immediate, including mid-operation): state=IDLE; all outputs 0 (`core_rst_n`=0, `cpu_enable`=0, `s_ready`=0, `wen_ext`=0, `ren_ext`=0, `addr_ext`=0, `cycle_count`=0, `error`=0); word counter and latched config cleared.
- States: IDLE, LOAD, VERIFY (optional), RUN, DONE. Registered state.
- IDLE/DONE + `start`:
  - Latch `num_words`/`run_cycles`, clear `cycle_count`, word index, `error` and checksum.
  - Go to LOAD, or to RUN if `num_words`==0.
- `start` while busy: ignored.
- LOAD:
  - `s_ready` (combinational) = 1 while accepted count < latched `num_words`.
  - Each `s_valid`&&`s_ready` cycle registers `wen_ext`=1, `wdata_ext`=`s_data`, `addr_ext`=4*index for exactly the next cycle; index increments. Back-to-back accepts give back-to-back write pulses.
  - `s_valid` low inserts bubbles and holds the index.
  - `wen_ext` is 0 in any cycle with no accepted word in the previous cycle.
  - The cycle the final write pulse is on `wen_ext`, the next state is RUN (or VERIFY). `s_ready` is 0 from the cycle after the last accept.
- `core_rst_n`=0 in IDLE, LOAD, VERIFY; 1 in RUN and DONE. DONE keeps data memory and register contents observable.
- RUN:
  - `cpu_enable`=1; `cycle_count` +1 each RUN cycle, counting from 1.
  - Exit to DONE when `stop`=1, or when `run_cycles`!=0 and `cycle_count`==`run_cycles` (that cycle is the last enabled cycle).
  - `stop` and limit in the same cycle: DONE, count unchanged by the tie.
  - `cycle_count` wraps at 2^CYC_W only when `run_cycles`==0.
- DONE: `cpu_enable`=0; `done`=1 until the next accepted `start`; `cycle_count` held.
- `ren_ext` is 0 outside VERIFY. External ports are never driven with `wen_ext` and `ren_ext` both high.

Optional Feature:
- Macro: CPU_BOOT_VERIFY_EN.
- Defined:
  - LOAD accumulates the XOR of all accepted words.
  - Then VERIFY issues `ren_ext` for addresses 0,4,…,4*(N-1), one per cycle, and XORs `rdata_ext` one cycle after each read.
  - After the last read data returns, if the checksums match, go to RUN. Otherwise set `error`=1 and go to DONE without enabling the core.
  - VERIFY takes N+1 cycles.
- Undefined: no VERIFY state, LOAD goes straight to RUN, `error` tied 0, `ren_ext` tied 0.

Test Plan:
1. Reset, start with `num_words`=3, `run_cycles`=10, continuous `s_valid` with words 0x00500093, 0x00A00113, 0x002081B3 -> `wen_ext` pulses at addr 0,4,8 on three consecutive cycles; `cpu_enable` high exactly 10 cycles; `done`=1; `cycle_count`=10.
2. Same load with `s_valid` toggling 1,0,1,0,1 -> writes at addr 0,4,8 only in the cycles after accepts; no extra `wen_ext`.
3. `run_cycles`=0, assert `stop` after 25 RUN cycles -> DONE with `cycle_count`=25; a `start` pulse while RUN is ignored.
4. `num_words`=0, `run_cycles`=5 -> no `wen_ext`; RUN 5 cycles; DONE.
5. Drop `arst_n` mid-LOAD after 2 of 4 words -> all outputs 0 immediately; after release, state IDLE with `s_ready`=0 until a new `start`.
6. (CPU_BOOT_VERIFY_EN) Load 2 words, corrupt memory model word at addr 4 -> `error`=1, DONE, `cpu_enable` never asserted. Uncorrupted -> RUN after 3 VERIFY cycles.
